// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline stall controller.
// Merges per-stage stall requests into one contiguous hold vector with
// fixed priority MEM > EX > ID > IF. It also runs a watchdog that raises a
// sticky flag when a stall lasts too long, and keeps saturating performance
// counters for the debug read path.
// The stall vector and source code are combinational. Everything else is
// registered on the rising edge of clk.

module stall_ctrl #(
    parameter int unsigned MAX_STALL = 200,
    parameter int unsigned WD_W      = 8,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if_i,
    input  logic             stallreq_id_i,
    input  logic             stallreq_ex_i,
    input  logic             stallreq_mem_i,
    input  logic             stat_clr_i,
    output logic [5:0]       stall,
    output logic [2:0]       stall_src_o,
    output logic             stall_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] stall_events_o,
    output logic [CNT_W-1:0] bubble_cycles_o
);

    typedef enum logic [1:0] {
        WD_IDLE    = 2'd0,
        WD_STALLED = 2'd1,
        WD_TIMEOUT = 2'd2
    } wd_state_e;

    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    wd_state_e        wd_state_q;
    logic [WD_W-1:0]  wd_cnt_q;
    logic [WD_W-1:0]  wd_inc_s;
    logic             wd_hit_s;
    logic             timeout_q;
    logic             prev_stall_q;

    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] evt_q, evt_d;
    logic [CNT_W-1:0] bub_q, bub_d;

    // Priority merge of stall requests. Every vector is contiguous from bit 0,
    // so the stage just above the top set bit receives a bubble.
    always_comb begin
        stall       = 6'b000000;
        stall_src_o = 3'd0;
        if (rst) begin
            stall       = 6'b000000;
            stall_src_o = 3'd0;
        end else if (stallreq_mem_i) begin
            stall       = 6'b011111;
            stall_src_o = 3'd4;
        end else if (stallreq_ex_i) begin
            stall       = 6'b001111;
            stall_src_o = 3'd3;
        end else if (stallreq_id_i) begin
            stall       = 6'b000111;
            stall_src_o = 3'd2;
        end else if (stallreq_if_i) begin
            stall       = 6'b000011;
            stall_src_o = 3'd1;
        end else begin
            stall       = 6'b000000;
            stall_src_o = 3'd0;
        end
    end

    // Watchdog limit detection. wd_cnt_q is 0 in IDLE, so the first stalled
    // cycle also goes through the increment path. This makes MAX_STALL=1
    // time out on the very first stalled edge.
    always_comb begin
        wd_inc_s = wd_cnt_q + WD_W'(1);
        if (stall[0] && (wd_state_q != WD_TIMEOUT)) begin
            wd_hit_s = (wd_inc_s == WD_LIMIT);
        end else begin
            wd_hit_s = 1'b0;
        end
    end

    // Watchdog FSM with its sticky timeout flag. The flag is cleared by
    // stat_clr_i, but that input leaves the state and the count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_state_q <= WD_IDLE;
            wd_cnt_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            case (wd_state_q)
                WD_IDLE, WD_STALLED: begin
                    if (stall[0]) begin
                        wd_cnt_q   <= wd_inc_s;
                        wd_state_q <= wd_hit_s ? WD_TIMEOUT : WD_STALLED;
                    end else begin
                        wd_cnt_q   <= '0;
                        wd_state_q <= WD_IDLE;
                    end
                end
                WD_TIMEOUT: begin
                    if (stall[0]) begin
                        wd_cnt_q   <= wd_cnt_q;
                        wd_state_q <= WD_TIMEOUT;
                    end else begin
                        wd_cnt_q   <= '0;
                        wd_state_q <= WD_IDLE;
                    end
                end
                default: begin
                    wd_cnt_q   <= '0;
                    wd_state_q <= WD_IDLE;
                end
            endcase

            if (stat_clr_i) begin
                timeout_q <= 1'b0;
            end else if (wd_hit_s) begin
                timeout_q <= 1'b1;
            end else begin
                timeout_q <= timeout_q;
            end
        end
    end

    // Next values of the saturating performance counters. A clear takes
    // priority over an increment in the same cycle.
    always_comb begin
        cyc_d = cyc_q;
        evt_d = evt_q;
        bub_d = bub_q;
        if (stat_clr_i) begin
            cyc_d = '0;
            evt_d = '0;
            bub_d = '0;
        end else begin
            if (stall[0] && (cyc_q != CNT_SAT)) begin
                cyc_d = cyc_q + CNT_ONE;
            end else begin
                cyc_d = cyc_q;
            end
            if (stall[0] && !prev_stall_q && (evt_q != CNT_SAT)) begin
                evt_d = evt_q + CNT_ONE;
            end else begin
                evt_d = evt_q;
            end
            if (stall[2] && !stall[3] && (bub_q != CNT_SAT)) begin
                bub_d = bub_q + CNT_ONE;
            end else begin
                bub_d = bub_q;
            end
        end
    end

    // Counter registers and the previous-cycle stall flop used for edge
    // detection. The flop resets to 0, so a request that is still high after
    // reset counts as a new episode.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q        <= '0;
            evt_q        <= '0;
            bub_q        <= '0;
            prev_stall_q <= 1'b0;
        end else begin
            cyc_q        <= cyc_d;
            evt_q        <= evt_d;
            bub_q        <= bub_d;
            prev_stall_q <= stall[0];
        end
    end

    assign stall_timeout_o = timeout_q;
    assign stall_cycles_o  = cyc_q;
    assign stall_events_o  = evt_q;
    assign bubble_cycles_o = bub_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl.
// The build uses MAX_STALL=4 and CNT_W=4, so the timeout and saturation
// cases can be reached in a few cycles.
// Each step drives inputs just after a rising edge and queues the
// hand-computed outputs expected during that cycle. A monitor pops one
// entry on each falling edge and compares it against the DUT outputs.

module tb_stall_ctrl;

    localparam logic [3:0] N   = 4'b0000;  // order {mem, ex, id, if}
    localparam logic [3:0] RIF = 4'b0001;
    localparam logic [3:0] RID = 4'b0010;
    localparam logic [3:0] REX = 4'b0100;
    localparam logic [3:0] RME = 4'b1000;
    localparam logic [3:0] ALL = 4'b1111;

    typedef struct {
        int         id;
        logic [5:0] st;
        logic [2:0] src;
        logic       to;
        logic [3:0] cyc;
        logic [3:0] evt;
        logic [3:0] bub;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_if = 1'b0, req_id = 1'b0, req_ex = 1'b0, req_mem = 1'b0;
    logic       clr = 1'b0;
    logic [5:0] stall;
    logic [2:0] src;
    logic       to;
    logic [3:0] cyc, evt, bub;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step_id = 0;

    stall_ctrl #(.MAX_STALL(4), .WD_W(8), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .stallreq_if_i   (req_if),
        .stallreq_id_i   (req_id),
        .stallreq_ex_i   (req_ex),
        .stallreq_mem_i  (req_mem),
        .stat_clr_i      (clr),
        .stall           (stall),
        .stall_src_o     (src),
        .stall_timeout_o (to),
        .stall_cycles_o  (cyc),
        .stall_events_o  (evt),
        .bubble_cycles_o (bub)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] req, input logic c,
                        input logic [5:0] es, input logic [2:0] esrc, input logic eto,
                        input int ecyc, input int eevt, input int ebub);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        {req_mem, req_ex, req_id, req_if} = req;
        clr = c;
        step_id++;
        e.id  = step_id;
        e.st  = es;
        e.src = esrc;
        e.to  = eto;
        e.cyc = 4'(ecyc);
        e.evt = 4'(eevt);
        e.bub = 4'(ebub);
        exp_q.push_back(e);
    endtask

    // Monitor: compare the DUT outputs with the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall",   e.id, 32'(stall), 32'(e.st));
            chk("src",     e.id, 32'(src),   32'(e.src));
            chk("timeout", e.id, 32'(to),    32'(e.to));
            chk("cycles",  e.id, 32'(cyc),   32'(e.cyc));
            chk("events",  e.id, 32'(evt),   32'(e.evt));
            chk("bubbles", e.id, 32'(bub),   32'(e.bub));
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Reset overrides all requests, then MEM wins after release.
        step(1'b1, ALL, 1'b0, 6'h00, 3'd0, 1'b0, 0, 0, 0);
        step(1'b0, ALL, 1'b0, 6'h1F, 3'd4, 1'b0, 0, 0, 0);
        step(1'b0, N,   1'b0, 6'h00, 3'd0, 1'b0, 1, 1, 0);
        // Single requests one at a time.
        step(1'b0, RIF, 1'b0, 6'h03, 3'd1, 1'b0, 1, 1, 0);
        step(1'b0, N,   1'b0, 6'h00, 3'd0, 1'b0, 2, 2, 0);
        step(1'b0, RID, 1'b0, 6'h07, 3'd2, 1'b0, 2, 2, 0);
        step(1'b0, N,   1'b0, 6'h00, 3'd0, 1'b0, 3, 3, 1);
        step(1'b0, REX, 1'b0, 6'h0F, 3'd3, 1'b0, 3, 3, 1);
        step(1'b0, N,   1'b0, 6'h00, 3'd0, 1'b0, 4, 4, 1);
        step(1'b0, RME, 1'b0, 6'h1F, 3'd4, 1'b0, 4, 4, 1);
        step(1'b0, N,   1'b1, 6'h00, 3'd0, 1'b0, 5, 5, 1);
        // ID held for 3 cycles.
        step(1'b0, RID, 1'b0, 6'h07, 3'd2, 1'b0, 0, 0, 0);
        step(1'b0, RID, 1'b0, 6'h07, 3'd2, 1'b0, 1, 1, 1);
        step(1'b0, RID, 1'b0, 6'h07, 3'd2, 1'b0, 2, 1, 2);
        step(1'b0, N,   1'b1, 6'h00, 3'd0, 1'b0, 3, 1, 3);
        // ID, EX, MEM back to back: one episode, 3 cycles, no timeout.
        step(1'b0, RID, 1'b0, 6'h07, 3'd2, 1'b0, 0, 0, 0);
        step(1'b0, REX, 1'b0, 6'h0F, 3'd3, 1'b0, 1, 1, 1);
        step(1'b0, RME, 1'b0, 6'h1F, 3'd4, 1'b0, 2, 1, 1);
        step(1'b0, N,   1'b1, 6'h00, 3'd0, 1'b0, 3, 1, 1);
        // EX held 4 cycles: timeout sets after the 4th edge and stays set.
        for (int k = 0; k < 4; k++)
            step(1'b0, REX, 1'b0, 6'h0F, 3'd3, 1'b0, k, (k >= 1) ? 1 : 0, 0);
        step(1'b0, N,   1'b0, 6'h00, 3'd0, 1'b1, 4, 1, 0);
        step(1'b0, N,   1'b0, 6'h00, 3'd0, 1'b1, 4, 1, 0);
        step(1'b0, N,   1'b1, 6'h00, 3'd0, 1'b1, 4, 1, 0);
        step(1'b0, N,   1'b0, 6'h00, 3'd0, 1'b0, 0, 0, 0);
        // A source change mid-stall does not restart the watchdog.
        step(1'b0, RID, 1'b0, 6'h07, 3'd2, 1'b0, 0, 0, 0);
        step(1'b0, REX, 1'b0, 6'h0F, 3'd3, 1'b0, 1, 1, 1);
        step(1'b0, RME, 1'b0, 6'h1F, 3'd4, 1'b0, 2, 1, 1);
        step(1'b0, RIF, 1'b0, 6'h03, 3'd1, 1'b0, 3, 1, 1);
        step(1'b0, N,   1'b1, 6'h00, 3'd0, 1'b1, 4, 1, 1);
        // 20 stalled cycles: the cycle counter saturates at 4'hF.
        for (int k = 0; k < 20; k++)
            step(1'b0, RME, 1'b0, 6'h1F, 3'd4, (k >= 4) ? 1'b1 : 1'b0,
                 (k > 15) ? 15 : k, (k >= 1) ? 1 : 0, 0);
        // Clear during a stalled cycle wins; the FSM stays in TIMEOUT.
        step(1'b0, RME, 1'b1, 6'h1F, 3'd4, 1'b1, 15, 1, 0);
        for (int j = 0; j < 5; j++)
            step(1'b0, RME, 1'b0, 6'h1F, 3'd4, 1'b0, j, 0, 0);
        // Reset mid-stall: a request still high afterwards is a new episode.
        step(1'b1, RME, 1'b0, 6'h00, 3'd0, 1'b0, 5, 0, 0);
        step(1'b0, RME, 1'b0, 6'h1F, 3'd4, 1'b0, 0, 0, 0);
        step(1'b0, RME, 1'b0, 6'h1F, 3'd4, 1'b0, 1, 1, 0);
        step(1'b0, N,   1'b0, 6'h00, 3'd0, 1'b0, 2, 1, 0);

        for (int w = 0; w < 100 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
